bmp_pixel_streamer: RTL and testbench

- Upstream feeder for the bounding-box stage. Parses a raw 24-bit BMP byte stream (header, pixel-offset gap, row padding).
- Emits one packed word per pixel colour byte: value in [31:24], running byte index in [23:0]. This is the exact word format and write-enable the box stage consumes.
- Supplies no backpressure downstream; downstream accepts every emitted word.

---
 rtl/bmp_pixel_streamer_if.sv | 21 ++
 rtl/bmp_pixel_streamer.sv | 157 +++++++++++++++
 tb/tb_bmp_pixel_streamer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bmp_pixel_streamer_if.sv
// rtl/bmp_pixel_streamer_if.sv - byte-in / word-out bundle for the BMP pixel streamer
interface bmp_pixel_streamer_if;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] out_word;
    logic        frame_done;
    logic        hdr_err;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, wr_en, out_word, frame_done, hdr_err
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, wr_en, out_word, frame_done, hdr_err
    );
endinterface

// File: rtl/bmp_pixel_streamer.sv
// rtl/bmp_pixel_streamer.sv - 24-bit BMP byte-stream parser emitting {byte, index} words
module bmp_pixel_streamer #(
    parameter int WIDTH  = 100,
    parameter int HEIGHT = 100,
    parameter int BPP    = 24
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    bmp_pixel_streamer_if.slave   bus
);
    localparam int RB = 3 * WIDTH;
    localparam int RS = ((RB + 3) / 4) * 4;
    localparam int CW = $clog2(RS + 1);
    localparam int RW = $clog2(HEIGHT + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_SKIP = 3'd2;
    localparam logic [2:0] S_PIX  = 3'd3;
    localparam logic [2:0] S_PAD  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    logic [2:0]    state;
    logic [31:0]   fcnt;
    logic [23:0]   idx;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0]    magic0, magic1;
    logic [31:0]   off, wid, hgt;
    logic [15:0]   bpp;
    logic          wr_en_q, frame_done_q, hdr_err_q;
    logic [31:0]   out_word_q;
    logic          in_ready;
    logic          acc;
    logic          hdr_ok;

    assign in_ready = ((state == S_HDR) || (state == S_SKIP) ||
                       (state == S_PIX) || (state == S_PAD)) && !bus.start;
    assign acc      = bus.in_valid && in_ready;

    assign hdr_ok = (magic0 == 8'h42) && (magic1 == 8'h4D) &&
                    (wid == 32'(WIDTH)) && (hgt == 32'(HEIGHT)) &&
                    (bpp == 16'(BPP)) &&
                    (off >= 32'd54) && (off < 32'd65536);

    assign bus.in_ready   = in_ready;
    assign bus.wr_en      = wr_en_q;
    assign bus.out_word   = out_word_q;
    assign bus.frame_done = frame_done_q;
    assign bus.hdr_err    = hdr_err_q;

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            fcnt         <= '0;
            idx          <= '0;
            col          <= '0;
            row          <= '0;
            magic0       <= '0;
            magic1       <= '0;
            off          <= '0;
            wid          <= '0;
            hgt          <= '0;
            bpp          <= '0;
            wr_en_q      <= 1'b0;
            out_word_q   <= '0;
            frame_done_q <= 1'b0;
            hdr_err_q    <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (bus.start) begin
                state        <= S_HDR;
                fcnt         <= '0;
                idx          <= '0;
                col          <= '0;
                row          <= '0;
                frame_done_q <= 1'b0;
                hdr_err_q    <= 1'b0;
            end else begin
                if (state == S_DONE)
                    frame_done_q <= 1'b1;
                if (acc) begin
                    if (fcnt != '1)
                        fcnt <= fcnt + 32'd1;
                    case (state)
                        S_HDR: begin
                            // fcnt stays below 54 in this state, so the low bits select the field
                            case (fcnt[5:0])
                                6'd0:  magic0      <= bus.in_data;
                                6'd1:  magic1      <= bus.in_data;
                                6'd10: off[7:0]    <= bus.in_data;
                                6'd11: off[15:8]   <= bus.in_data;
                                6'd12: off[23:16]  <= bus.in_data;
                                6'd13: off[31:24]  <= bus.in_data;
                                6'd18: wid[7:0]    <= bus.in_data;
                                6'd19: wid[15:8]   <= bus.in_data;
                                6'd20: wid[23:16]  <= bus.in_data;
                                6'd21: wid[31:24]  <= bus.in_data;
                                6'd22: hgt[7:0]    <= bus.in_data;
                                6'd23: hgt[15:8]   <= bus.in_data;
                                6'd24: hgt[23:16]  <= bus.in_data;
                                6'd25: hgt[31:24]  <= bus.in_data;
                                6'd28: bpp[7:0]    <= bus.in_data;
                                6'd29: bpp[15:8]   <= bus.in_data;
                                default: ;
                            endcase
                            if (fcnt == 32'd53) begin
                                if (!hdr_ok) begin
                                    state     <= S_ERR;
                                    hdr_err_q <= 1'b1;
                                end else if (off > 32'd54) begin
                                    state <= S_SKIP;
                                end else begin
                                    state <= S_PIX;
                                end
                            end
                        end
                        S_SKIP: begin
                            if (fcnt == off - 32'd1)
                                state <= S_PIX;
                        end
                        S_PIX: begin
                            wr_en_q    <= 1'b1;
                            out_word_q <= {bus.in_data, idx};
                            idx        <= idx + 24'd1;
                            if (col == CW'(RB - 1)) begin
                                if (row == RW'(HEIGHT - 1)) begin
                                    state <= S_DONE;
                                end else if (RS > RB) begin
                                    col   <= CW'(RB);
                                    state <= S_PAD;
                                end else begin
                                    col <= '0;
                                    row <= row + RW'(1);
                                end
                            end else begin
                                col <= col + CW'(1);
                            end
                        end
                        S_PAD: begin
                            // col keeps counting through the stride so pad length needs no extra counter
                            if (col == CW'(RS - 1)) begin
                                col   <= '0;
                                row   <= row + RW'(1);
                                state <= S_PIX;
                            end else begin
                                col <= col + CW'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_bmp_pixel_streamer.sv
// tb/tb_bmp_pixel_streamer.sv - directed self-checking bench for bmp_pixel_streamer
module tb_bmp_pixel_streamer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bmp_pixel_streamer_if big_if ();
    bmp_pixel_streamer_if small_if ();

    bmp_pixel_streamer u_big (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .bus      (big_if)
    );

    bmp_pixel_streamer #(.WIDTH(5), .HEIGHT(2), .BPP(24)) u_small (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .bus      (small_if)
    );

    logic        sel = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, wr_en, frame_done, hdr_err;
    logic [31:0] out_word;

    assign big_if.start      = start & ~sel;
    assign big_if.in_valid   = in_valid & ~sel;
    assign big_if.in_data    = in_data;
    assign small_if.start    = start & sel;
    assign small_if.in_valid = in_valid & sel;
    assign small_if.in_data  = in_data;

    assign in_ready   = sel ? small_if.in_ready   : big_if.in_ready;
    assign wr_en      = sel ? small_if.wr_en      : big_if.wr_en;
    assign out_word   = sel ? small_if.out_word   : big_if.out_word;
    assign frame_done = sel ? small_if.frame_done : big_if.frame_done;
    assign hdr_err    = sel ? small_if.hdr_err    : big_if.hdr_err;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix_byte(input int p);
        return 8'((p * 7 + 3) & 255);
    endfunction

    function automatic logic [7:0] file_byte(input int p, input int w, input int h,
                                             input int bp, input int off, input logic [7:0] m1);
        if (p >= 54) return pix_byte(p);
        case (p)
            0:  return 8'h42;
            1:  return m1;
            10, 11, 12, 13: return 8'(off >> (8 * (p - 10)));
            18, 19, 20, 21: return 8'(w >> (8 * (p - 18)));
            22, 23, 24, 25: return 8'(h >> (8 * (p - 22)));
            28, 29:         return 8'(bp >> (8 * (p - 28)));
            default:        return 8'h00;
        endcase
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int mon_off = 54, mon_rb = 15, mon_rs = 16;
    int got_cnt = 0, bad_words = 0, last_wr_cyc = 0, fd_cyc = 0;
    bit fd_seen = 1'b0;
    logic [31:0] first_word = '0, w15 = '0, last_word = '0;

    always @(negedge clk) begin
        if (wr_en) begin
            logic [31:0] exp_w;
            exp_w = {pix_byte(mon_off + (got_cnt / mon_rb) * mon_rs + (got_cnt % mon_rb)), 24'(got_cnt)};
            if (out_word !== exp_w) bad_words++;
            if (got_cnt == 0) first_word = out_word;
            if (got_cnt == 15) w15 = out_word;
            last_word = out_word;
            last_wr_cyc = cyc;
            got_cnt++;
        end
        if (frame_done && !fd_seen) begin
            fd_seen = 1'b1;
            fd_cyc = cyc;
        end
    end

    task automatic clear_mon(input int off, input int rb, input int rs);
        mon_off = off; mon_rb = rb; mon_rs = rs;
        got_cnt = 0; bad_words = 0; last_wr_cyc = 0; fd_cyc = 0; fd_seen = 1'b0;
        first_word = '0; w15 = '0; last_word = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // presents file bytes until nbytes, the DUT stops accepting, or abort/stop position
    task automatic send_file(input int w, input int h, input int bp, input int off,
                             input logic [7:0] m1, input int nbytes, input int gap_pct,
                             input int abort_at, input int stop_at, output int accepted);
        bit ok;
        accepted = 0;
        for (int p = 0; p < nbytes; p++) begin
            if (p == abort_at) begin
                start = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
                tick();
                start = 1'b0; in_valid = 1'b0;
                return;
            end
            if (p == stop_at) begin
                in_valid = 1'b0;
                return;
            end
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = file_byte(p, w, h, bp, off, m1);
            #1;
            ok = in_ready;
            tick();
            if (!ok) begin
                in_valid = 1'b0;
                return;
            end
            accepted++;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    int acc;

    initial begin
        reset_n = 1'b0;
        repeat (3) tick();
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_out_word", out_word, 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_hdr_err", 32'(hdr_err), 0);
        reset_n = 1'b1;
        in_valid = 1'b1;
        #1;
        check("idle_in_ready", 32'(in_ready), 0);
        in_valid = 1'b0;
        tick();

        // full 100x100 frame, back-to-back
        sel = 1'b0;
        clear_mon(54, 300, 300);
        pulse_start();
        send_file(100, 100, 24, 54, 8'h4D, 30054, 0, -1, -1, acc);
        repeat (3) tick();
        check("big_count", got_cnt, 30000);
        check("big_words", bad_words, 0);
        check("big_first", first_word, 32'h7D000000);
        check("big_last", last_word, 32'hC600752F);
        check("big_done_lat", fd_cyc - last_wr_cyc, 1);
        check("big_accepted", acc, 30054);
        check("big_done_ready", 32'(in_ready), 0);
        check("big_hdr_err", 32'(hdr_err), 0);

        // 5x2 frame with one pad byte per row
        sel = 1'b1;
        clear_mon(54, 15, 16);
        pulse_start();
        send_file(5, 2, 24, 54, 8'h4D, 86, 0, -1, -1, acc);
        repeat (3) tick();
        check("sm_count", got_cnt, 30);
        check("sm_words", bad_words, 0);
        check("sm_w15", w15, 32'hED00000F);
        check("sm_last", last_word, 32'h4F00001D);
        check("sm_accepted", acc, 85);
        check("sm_done", 32'(frame_done), 1);
        check("sm_done_lat", fd_cyc - last_wr_cyc, 1);

        // pixel offset 60
        clear_mon(60, 15, 16);
        pulse_start();
        send_file(5, 2, 24, 60, 8'h4D, 92, 0, -1, -1, acc);
        repeat (3) tick();
        check("off60_first", first_word, 32'hA7000000);
        check("off60_count", got_cnt, 30);
        check("off60_words", bad_words, 0);
        check("off60_accepted", acc, 91);

        // rejected headers: width, bpp, magic
        for (int k = 0; k < 3; k++) begin
            clear_mon(54, 15, 16);
            pulse_start();
            send_file((k == 0) ? 4 : 5, 2, (k == 1) ? 32 : 24, 54,
                      (k == 2) ? 8'h4E : 8'h4D, 86, 0, -1, -1, acc);
            repeat (3) tick();
            check($sformatf("err%0d_hdr_err", k), 32'(hdr_err), 1);
            check($sformatf("err%0d_ready", k), 32'(in_ready), 0);
            check($sformatf("err%0d_words", k), got_cnt, 0);
            check($sformatf("err%0d_accepted", k), acc, 54);
        end

        // recovery after error, with random gaps
        clear_mon(54, 15, 16);
        pulse_start();
        send_file(5, 2, 24, 54, 8'h4D, 86, 30, -1, -1, acc);
        repeat (3) tick();
        check("rec_hdr_err", 32'(hdr_err), 0);
        check("rec_count", got_cnt, 30);
        check("rec_words", bad_words, 0);
        check("rec_done", 32'(frame_done), 1);

        // start mid-frame with a byte offered in the start cycle
        clear_mon(54, 15, 16);
        pulse_start();
        send_file(5, 2, 24, 54, 8'h4D, 86, 30, 66, -1, acc);
        check("abort_partial", got_cnt, 12);
        clear_mon(54, 15, 16);
        send_file(5, 2, 24, 54, 8'h4D, 86, 30, -1, -1, acc);
        repeat (3) tick();
        check("abort_count", got_cnt, 30);
        check("abort_words", bad_words, 0);
        check("abort_first", first_word, 32'h7D000000);
        check("abort_done", 32'(frame_done), 1);

        // reset pulse mid-PIX
        clear_mon(54, 15, 16);
        pulse_start();
        send_file(5, 2, 24, 54, 8'h4D, 86, 0, -1, 60, acc);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mrst_wr_en", 32'(wr_en), 0);
        check("mrst_out_word", out_word, 0);
        check("mrst_flags", {30'd0, frame_done, hdr_err}, 0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        #1;
        check("mrst_ready", 32'(in_ready), 0);
        tick();
        check("mrst_wr_en2", 32'(wr_en), 0);
        in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
